// File: rtl/decision_unit.sv
// Decision responder: scans the variable-state vector for the first unassigned variable,
// writes one decision at the next level and owns the level counter. Optional macro: DECISION_POLARITY_TRUE_EN.
module decision_unit #(
  parameter int unsigned WIDTH_LVL   = 16,
  parameter int unsigned NUM_VARS    = 8,
  parameter int unsigned NUM_CLAUSES = 8,
  parameter int unsigned WIDTH_VAR   = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_decision_i,
  input  logic [2*NUM_VARS-1:0]  var_value_i,
  input  logic [NUM_CLAUSES-1:0] clause_sat_i,
  input  logic                   load_lvl_i,
  input  logic [WIDTH_LVL-1:0]   lvl_i,
  output logic                   done_decision_o,
  output logic                   all_c_is_sat_o,
  output logic [WIDTH_LVL-1:0]   cur_lvl_o,
  output logic                   wr_var_en_o,
  output logic [WIDTH_VAR-1:0]   wr_var_idx_o,
  output logic [1:0]             wr_var_value_o,
  output logic [WIDTH_LVL-1:0]   wr_var_lvl_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    ASSIGN = 2'd2,
    DONE   = 2'd3
  } state_t;

`ifdef DECISION_POLARITY_TRUE_EN
  localparam logic [1:0] DECISION_VALUE = 2'b10;
`else
  localparam logic [1:0] DECISION_VALUE = 2'b01;
`endif

  localparam logic [WIDTH_VAR-1:0] LAST_IDX = WIDTH_VAR'(NUM_VARS - 1);
  localparam logic [1:0]           UNASSIGNED = 2'b00;

  state_t                 state_q, state_d;
  logic [WIDTH_VAR-1:0]   idx_q, idx_d;
  logic                   done_q, done_d;
  logic                   all_sat_q, all_sat_d;
  logic [WIDTH_LVL-1:0]   cur_lvl_q, cur_lvl_d;
  logic                   wr_en_q, wr_en_d;
  logic [WIDTH_VAR-1:0]   wr_idx_q, wr_idx_d;
  logic [1:0]             wr_val_q, wr_val_d;
  logic [WIDTH_LVL-1:0]   wr_lvl_q, wr_lvl_d;

  logic [1:0]             cur_var_state_c;
  logic                   all_clauses_sat_c;

  // State of the variable under the scan pointer; out-of-range indices read as assigned.
  always_comb begin
    cur_var_state_c = 2'b11;
    for (int i = 0; i < int'(NUM_VARS); i++) begin
      if (idx_q == WIDTH_VAR'(i)) begin
        cur_var_state_c = var_value_i[2*i +: 2];
      end
    end
  end

  assign all_clauses_sat_c = &clause_sat_i;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      done_q    <= 1'b0;
      all_sat_q <= 1'b0;
      cur_lvl_q <= '0;
      wr_en_q   <= 1'b0;
      wr_idx_q  <= '0;
      wr_val_q  <= 2'b00;
      wr_lvl_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      all_sat_q <= all_sat_d;
      cur_lvl_q <= cur_lvl_d;
      wr_en_q   <= wr_en_d;
      wr_idx_q  <= wr_idx_d;
      wr_val_q  <= wr_val_d;
      wr_lvl_q  <= wr_lvl_d;
    end
  end

  // Next-state and next-output logic; a backtrack load overrides the decision increment.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    all_sat_d = all_sat_q;
    cur_lvl_d = load_lvl_i ? lvl_i : cur_lvl_q;
    wr_en_d   = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_val_d  = wr_val_q;
    wr_lvl_d  = wr_lvl_q;

    unique case (state_q)
      IDLE: begin
        if (start_decision_i) begin
          state_d   = SCAN;
          idx_d     = '0;
          all_sat_d = 1'b0;
        end
      end

      SCAN: begin
        if (all_clauses_sat_c) begin
          state_d   = DONE;
          done_d    = 1'b1;
          all_sat_d = 1'b1;
        end else if (cur_var_state_c == UNASSIGNED) begin
          state_d  = ASSIGN;
          wr_en_d  = 1'b1;
          wr_idx_d = idx_q;
          wr_val_d = DECISION_VALUE;
          // Tag with the level the ASSIGN cycle will present, including a load landing now.
          wr_lvl_d = cur_lvl_d + WIDTH_LVL'(1);
        end else if (idx_q == LAST_IDX) begin
          state_d   = DONE;
          done_d    = 1'b1;
          all_sat_d = 1'b1;
        end else begin
          idx_d = idx_q + WIDTH_VAR'(1);
        end
      end

      ASSIGN: begin
        state_d = DONE;
        done_d  = 1'b1;
        if (!load_lvl_i) begin
          cur_lvl_d = cur_lvl_q + WIDTH_LVL'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign done_decision_o = done_q;
  assign all_c_is_sat_o  = all_sat_q;
  assign cur_lvl_o       = cur_lvl_q;
  assign wr_var_en_o     = wr_en_q;
  assign wr_var_idx_o    = wr_idx_q;
  assign wr_var_value_o  = wr_val_q;
  assign wr_var_lvl_o    = wr_lvl_q;

endmodule

// File: doc/decision_unit.md
# decision_unit

Responder for the solver core's decision request: on a single-cycle start pulse it scans the variable-state vector for the first unassigned variable, emits one assignment write at a new decision level, and returns a one-cycle done pulse with the updated level. If every clause is already satisfied, or no unassigned variable remains, it reports all-satisfied instead of writing. It sits beside the BCP and conflict-analysis units inside the sat engine. It answers `start_decision`, returns `done_decision`, `cur_lvl` and `all_c_is_sat`, and owns the decision-level counter.

## Interface
- WIDTH_LVL, 16, decision-level width; NUM_VARS < 2^WIDTH_LVL is required
- NUM_VARS, 8, variables held in the current bin
- NUM_CLAUSES, 8, clauses held in the current bin
- WIDTH_VAR, 3, variable index width; 2^WIDTH_VAR >= NUM_VARS
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start_decision_i  in  1  one-cycle request pulse
- var_value_i  in  2*NUM_VARS  per-variable state, var i at [2i+1:2i]
  - 00 = unassigned, 01 = false, 10 = true, 11 = treated as assigned
- clause_sat_i  in  NUM_CLAUSES  per-clause satisfied flags
- load_lvl_i  in  1  overwrite level counter (used by backtrack)
- lvl_i  in  WIDTH_LVL  value loaded when load_lvl_i=1
- done_decision_o  out  1  one-cycle completion pulse
- all_c_is_sat_o  out  1  result flag, valid with done, held until next accepted start
- cur_lvl_o  out  WIDTH_LVL  current decision level
- wr_var_en_o  out  1  one-cycle assignment write strobe
- wr_var_idx_o  out  WIDTH_VAR  index of the decided variable
- wr_var_value_o  out  2  value written (polarity; see Configuration)
- wr_var_lvl_o  out  WIDTH_LVL  level tagged on the write (= cur_lvl_o+1)

## Operation
- FSM states: IDLE, SCAN, ASSIGN, DONE. All outputs are registered.
- IDLE
  - start_decision_i=1 → SCAN; idx←0; all_c_is_sat_o←0.
  - Otherwise stay in IDLE.
- SCAN: evaluated each cycle, in priority order:
  1. &clause_sat_i=1 → DONE, all_c_is_sat_o←1.
  2. var idx unassigned (00) → ASSIGN; latch idx; wr_var_en_o←1.
  3. idx==NUM_VARS-1 → DONE, all_c_is_sat_o←1 (fully assigned, no conflict).
  4. Otherwise idx←idx+1.
- ASSIGN (one cycle)
  - wr_var_en_o=1; wr_var_idx_o=latched idx; wr_var_lvl_o=cur_lvl_o+1.
  - At exit: cur_lvl_o←cur_lvl_o+1; → DONE.
- DONE (one cycle): done_decision_o=1 → IDLE.
- start_decision_i is ignored outside IDLE.
- Level counter
  - load_lvl_i=1 has priority over the ASSIGN increment (cur_lvl_o←lvl_i) and is honoured in any state.
  - Increment wraps modulo 2^WIDTH_LVL; no overflow check.
  - A load during ASSIGN does not alter that cycle's wr_var_lvl_o.
- wr_var_idx_o, wr_var_value_o and wr_var_lvl_o hold their last values when wr_var_en_o=0.

## Timing
- Reset values (rst=0 at a clk edge): state IDLE; every output 0, including cur_lvl_o. A reset mid-scan aborts the scan with no write and no done pulse.
- Start accepted at edge T; first SCAN cycle is T+1.
- First unassigned variable at index k:
  - wr_var_en_o high in cycle T+2+k.
  - done_decision_o high in cycle T+3+k.
  - New cur_lvl_o visible in the done cycle.
- No unassigned variable: done_decision_o at T+1+NUM_VARS with all_c_is_sat_o=1.
- All clauses satisfied at the first SCAN cycle: done at T+2.
- var_value_i and clause_sat_i are sampled live during SCAN. The requester keeps them stable from start until done.
- Minimum spacing between accepted starts: 3 cycles. Back-to-back starts (done cycle, then start the following cycle) are legal.

## Configuration
- DECISION_POLARITY_TRUE_EN
  - Defined: wr_var_value_o=2'b10 (true) on every decision.
  - Undefined: wr_var_value_o=2'b01 (false).
  - No other behaviour changes.

## Test plan
- Reset, then start with var_value_i=all 00, clause_sat_i=0: wr_var_en_o at T+2 with idx 0, lvl 1; done at T+3; cur_lvl_o=1; all_c_is_sat_o=0.
- Vars 0–4 assigned, var 5 unassigned: write idx 5, lvl=prev+1 at T+7; done at T+8.
- All vars assigned, clause_sat_i≠all-ones: no write; done at T+1+NUM_VARS with all_c_is_sat_o=1; level unchanged.
- clause_sat_i all ones at start: done at T+2, all_c_is_sat_o=1, no write.
- load_lvl_i=1, lvl_i=3 coincident with ASSIGN at cur_lvl_o=6: write carries lvl 7; cur_lvl_o=3 afterwards. Second start pulse mid-scan is ignored (exactly one done).
- rst=0 during SCAN: all outputs 0 next cycle, no done. Repeat a decision with and without DECISION_POLARITY_TRUE_EN: value 10 vs 01.
